// File: rtl/add4_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : add4_accumulator
// Summary  : Sums bursts of COUNT unsigned operands and presents each burst
//            total on a valid/ready port. Define ADD4_ACC_SATURATE_EN to
//            clamp the running total at 2^WIDTH-1 instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module add4_accumulator #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4,
    parameter int CW    = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CW-1:0]    out_count
);

    localparam logic [1:0]    c_st_idle  = 2'd0;
    localparam logic [1:0]    c_st_accum = 2'd1;
    localparam logic [1:0]    c_st_hold  = 2'd2;
    localparam logic [CW-1:0] c_count    = CW'(COUNT);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_next_acc;
    logic [CW-1:0]    w_cnt_inc;

    assign in_ready  = (r_state != c_st_hold);
    assign out_valid = (r_state == c_st_hold);
    assign w_accept  = in_valid & in_ready;

    assign w_sum     = {1'b0, r_acc} + {1'b0, in_data};
    assign w_carry   = w_sum[WIDTH];
    assign w_cnt_inc = r_cnt + CW'(1);

`ifdef ADD4_ACC_SATURATE_EN
    // Once clamped, any further add either carries again or adds zero,
    // so the total naturally stays pinned at full scale.
    assign w_next_acc = w_carry ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_next_acc = w_sum[WIDTH-1:0];
`endif

    // The result fields are forced to zero whenever no result is offered.
    assign out_sum   = out_valid ? r_acc : '0;
    assign out_ovf   = out_valid & r_ovf;
    assign out_count = out_valid ? r_cnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_acc <= in_data;
                        r_ovf <= 1'b0;
                        r_cnt <= CW'(1);
                        if ((COUNT == 1) || flush) begin
                            r_state <= c_st_hold;
                        end else begin
                            r_state <= c_st_accum;
                        end
                    end
                end
                c_st_accum: begin
                    if (w_accept) begin
                        r_acc <= w_next_acc;
                        r_ovf <= r_ovf | w_carry;
                        r_cnt <= w_cnt_inc;
                        if ((w_cnt_inc == c_count) || flush) begin
                            r_state <= c_st_hold;
                        end
                    end else if (flush) begin
                        r_state <= c_st_hold;
                    end
                end
                c_st_hold: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
